regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/rv_pkg.sv | 18 +
 rtl/regfile_writeback_if.sv | 53 +++++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/regfile_writeback.sv | 99 +++++++++
 tb/tb_regfile_writeback.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V datapath types: register index and data widths plus the
// writeback entry carried through the load-result buffer.
package rv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // x0 is hardwired to zero, so results aimed at it never reach the file.
    function automatic logic is_arch_reg(input logic [REG_IDX_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: ALU and load result channels plus the register-file write port.
// Forwarding query ports exist only when WB_FWD_EN is defined.
interface regfile_writeback_if;
    import rv_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;

    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_rd;
    logic [XLEN-1:0]      mem_data;

    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic [XLEN-1:0]      rdData;

`ifdef WB_FWD_EN
    logic [REG_IDX_W-1:0] fwd_rs1;
    logic [REG_IDX_W-1:0] fwd_rs2;
    logic                 fwd_hit1;
    logic                 fwd_hit2;
    logic [XLEN-1:0]      fwd_data1;
    logic [XLEN-1:0]      fwd_data2;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output rd, wen, rdData
`ifdef WB_FWD_EN
        ,
        input  fwd_rs1, fwd_rs2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  rd, wen, rdData
`ifdef WB_FWD_EN
        ,
        output fwd_rs1, fwd_rs2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries buffering load results until they win
// the write port. DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop frees its slot in time for a same-cycle push, even when full.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the single register-file write port.
// Defining WB_FWD_EN adds combinational forwarding from the registered write.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  wb
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    wb_entry_t            fifo_head;
    wb_entry_t            mem_entry;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 throttle;
    logic                 alu_fire;
    logic                 mem_fire;
    logic                 fifo_pop;

    logic [SW-1:0]        starve_q, starve_d;
    logic                 wen_q, wen_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]      data_q, data_d;

    assign mem_entry.rd   = wb.mem_rd;
    assign mem_entry.data = wb.mem_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_fire),
        .push_data (mem_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign throttle     = (starve_q == SW'(STARVE_LIMIT));
    assign wb.alu_ready = rst || !throttle;
    assign wb.mem_ready = rst || !fifo_full;

    // ALU wins the port unless it is throttled; x0 results retire silently.
    always_comb begin
        alu_fire = wb.alu_valid && !throttle && !rst;
        mem_fire = wb.mem_valid && !fifo_full && !rst;
        fifo_pop = !alu_fire && !fifo_empty && !rst;
        starve_d = (fifo_full && alu_fire) ? starve_q + SW'(1) : '0;
        wen_d    = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        if (alu_fire) begin
            if (is_arch_reg(wb.alu_rd)) begin
                wen_d  = 1'b1;
                rd_d   = wb.alu_rd;
                data_d = wb.alu_data;
            end
        end else if (fifo_pop) begin
            if (is_arch_reg(fifo_head.rd)) begin
                wen_d  = 1'b1;
                rd_d   = fifo_head.rd;
                data_d = fifo_head.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    assign wb.wen    = wen_q;
    assign wb.rd     = rd_q;
    assign wb.rdData = data_q;

`ifdef WB_FWD_EN
    assign wb.fwd_hit1  = wen_q && is_arch_reg(rd_q) && (rd_q == wb.fwd_rs1);
    assign wb.fwd_hit2  = wen_q && is_arch_reg(rd_q) && (rd_q == wb.fwd_rs2);
    assign wb.fwd_data1 = data_q;
    assign wb.fwd_data2 = data_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback against a queue-based
// reference model; forwarding checks are compiled in with WB_FWD_EN.
module tb_regfile_writeback;
    import rv_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic rst;
    int   numChecks = 0;
    int   numFails  = 0;

    regfile_writeback_if bus ();

    regfile_writeback #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    wb_entry_t   modelQ[$];
    int          modelStarve = 0;
    logic        expWen  = 1'b0;
    logic [4:0]  expRd   = '0;
    logic [31:0] expData = '0;
    logic        lastAluReady;
    logic        lastMemReady;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check readies, step the model,
    // then check the registered write port just after the rising edge.
    task automatic applyStimulus(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
        logic      expAluReady, expMemReady, aluTaken, memTaken, haveWrite, wasFull;
        wb_entry_t wr, e;
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = mdata;
        #1;
        expAluReady  = r || (modelStarve != STARVE_LIMIT);
        expMemReady  = r || (modelQ.size() < FIFO_DEPTH);
        lastAluReady = bus.alu_ready;
        lastMemReady = bus.mem_ready;
        checkOutput("alu_ready", bus.alu_ready, expAluReady);
        checkOutput("mem_ready", bus.mem_ready, expMemReady);
        if (r) begin
            modelQ.delete();
            modelStarve = 0;
            expWen      = 1'b0;
            expRd       = '0;
            expData     = '0;
        end else begin
            aluTaken  = av && expAluReady;
            memTaken  = mv && expMemReady;
            wasFull   = (modelQ.size() == FIFO_DEPTH);
            haveWrite = 1'b0;
            wr        = '0;
            if (aluTaken) begin
                haveWrite = 1'b1;
                wr.rd     = ard;
                wr.data   = adata;
            end else if (modelQ.size() > 0) begin
                haveWrite = 1'b1;
                wr        = modelQ.pop_front();
            end
            modelStarve = (wasFull && aluTaken) ? modelStarve + 1 : 0;
            if (memTaken) begin
                e.rd   = mrd;
                e.data = mdata;
                modelQ.push_back(e);
            end
            expWen = haveWrite && (wr.rd != 0);
            if (expWen) begin
                expRd   = wr.rd;
                expData = wr.data;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("wen", bus.wen, expWen);
        checkOutput("rd", bus.rd, expRd);
        checkOutput("rdData", bus.rdData, expData);
`ifdef WB_FWD_EN
        checkOutput("fwd_hit1", bus.fwd_hit1, expWen && (expRd != 0) && (expRd == bus.fwd_rs1));
        checkOutput("fwd_hit2", bus.fwd_hit2, expWen && (expRd != 0) && (expRd == bus.fwd_rs2));
        if (bus.fwd_hit1) checkOutput("fwd_data1", bus.fwd_data1, expData);
        if (bus.fwd_hit2) checkOutput("fwd_data2", bus.fwd_data2, expData);
`endif
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int idx;
        rst           = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
`ifdef WB_FWD_EN
        bus.fwd_rs1   = '0;
        bus.fwd_rs2   = '0;
`endif
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("reset_wen", bus.wen, 0);
        checkOutput("reset_rd", bus.rd, 0);
        checkOutput("reset_rdData", bus.rdData, 0);

        $display("[TB] ALU single-cycle latency");
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        checkOutput("alu_lat_wen", bus.wen, 1);
        checkOutput("alu_lat_rd", bus.rd, 5);
        checkOutput("alu_lat_data", bus.rdData, 32'hDEADBEEF);
        idle();
        checkOutput("alu_pulse_end", bus.wen, 0);
        checkOutput("alu_hold_data", bus.rdData, 32'hDEADBEEF);

        $display("[TB] load two-cycle latency");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        checkOutput("load_not_early", bus.wen, 0);
        idle();
        checkOutput("load_lat_wen", bus.wen, 1);
        checkOutput("load_lat_rd", bus.rd, 7);
        checkOutput("load_lat_data", bus.rdData, 32'h11);

        $display("[TB] starvation throttle");
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b1, 5'(10 + c), 32'(c), idx <= 3, 5'(idx), 32'(100 + idx));
            if (c == 2) checkOutput("full_blocks_mem", lastMemReady, 0);
            if (c == 4) checkOutput("no_throttle_early", lastAluReady, 1);
            if (c == 5) checkOutput("starve_throttle", lastAluReady, 0);
            if (c == 5) checkOutput("throttle_pops_rd1", bus.rd, 1);
            if (lastMemReady && idx <= 3) idx++;
        end
        repeat (3) idle();

        $display("[TB] x0 results dropped");
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h6666);
        checkOutput("x0_alu_no_wen", bus.wen, 0);
        idle();
        checkOutput("x0_load_no_wen", bus.wen, 0);
        idle();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'hB1);
        applyStimulus(1'b0, 1'b1, 5'd21, 32'hA1, 1'b1, 5'd2, 32'hB2);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("rst_mid_wen", bus.wen, 0);
        idle();
        checkOutput("rst_mem_ready", lastMemReady, 1);
        checkOutput("rst_no_write1", bus.wen, 0);
        idle();
        checkOutput("rst_no_write2", bus.wen, 0);

`ifdef WB_FWD_EN
        $display("[TB] forwarding");
        bus.fwd_rs1 = 5'd9;
        bus.fwd_rs2 = 5'd0;
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h42, 1'b0, 5'd0, 32'd0);
        checkOutput("fwd_hit1_dir", bus.fwd_hit1, 1);
        checkOutput("fwd_data1_dir", bus.fwd_data1, 32'h42);
        checkOutput("fwd_hit2_dir", bus.fwd_hit2, 0);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
`ifdef WB_FWD_EN
            bus.fwd_rs1 = 5'($urandom_range(0, 31));
            bus.fwd_rs2 = 5'($urandom_range(0, 31));
`endif
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
